// File: rtl/multi_ch_crg_ctrl.sv
// Multi-channel clock/reset sequencer: per-channel gated enable, glitch-safe clock select,
// sequenced reset and idle auto-gating. One lane FSM per channel, every output registered.

module multi_ch_crg_lane #(
    parameter int SEL_W       = 1,
    parameter int RST_CYCLES  = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int SW_GAP      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_on,
    input  logic             busy,
    input  logic [SEL_W-1:0] sel_req,
    output logic             clk_en,
    output logic [SEL_W-1:0] clk_sel,
    output logic             ch_rst,
    output logic             ready,
    output logic [2:0]       state_code
);
    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_RST_ON  = 3'd1,
        S_ON      = 3'd2,
        S_IDLE    = 3'd3,
        S_SW      = 3'd4,
        S_RST_OFF = 3'd5
    } state_e;

    localparam int RST_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int GAP_W  = $clog2(SW_GAP + 1);
    localparam int IDLE_W = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
    localparam bit AUTO_GATE = (IDLE_CYCLES != 0);

    localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(SW_GAP);
    localparam logic [IDLE_W:0]   IDLE_THR  = (IDLE_W + 1)'(IDLE_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_SAT  = '1;

    state_e             state;
    logic [2:0]         outs;        // {clk_en, ch_rst, ready}
    logic [RST_W-1:0]   rst_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [IDLE_W-1:0]  idle_cnt;
    logic               idle_hit;
    logic               sel_diff;

    function automatic logic [2:0] out_of(input state_e s);
        case (s)
            S_OFF:               out_of = 3'b010;
            S_RST_ON, S_RST_OFF: out_of = 3'b110;
            S_ON:                out_of = 3'b101;
            default:             out_of = 3'b000;
        endcase
    endfunction

    assign idle_hit   = AUTO_GATE && (({1'b0, idle_cnt} + (IDLE_W + 1)'(1)) >= IDLE_THR);
    assign sel_diff   = (sel_req != clk_sel);
    assign {clk_en, ch_rst, ready} = outs;
    assign state_code = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_OFF;
            outs     <= 3'b010;
            clk_sel  <= '0;
            rst_cnt  <= '0;
            gap_cnt  <= '0;
            idle_cnt <= '0;
        end else begin
            case (state)
                S_OFF: begin
                    if (req_on) begin
                        state   <= S_RST_ON;
                        outs    <= out_of(S_RST_ON);
                        clk_sel <= sel_req;
                        rst_cnt <= '0;
                    end
                end
                S_RST_ON: begin
                    if (!req_on) begin
                        state   <= S_RST_OFF;
                        outs    <= out_of(S_RST_OFF);
                        rst_cnt <= '0;
                    end else if (rst_cnt == RST_LAST) begin
                        state    <= S_ON;
                        outs     <= out_of(S_ON);
                        rst_cnt  <= '0;
                        idle_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + RST_W'(1);
                    end
                end
                S_ON: begin
                    if (!req_on) begin
                        state    <= S_RST_OFF;
                        outs     <= out_of(S_RST_OFF);
                        rst_cnt  <= '0;
                        idle_cnt <= '0;
                    end else if (sel_diff) begin
                        state    <= S_SW;
                        outs     <= out_of(S_SW);
                        gap_cnt  <= '0;
                        idle_cnt <= '0;
                    end else if (busy) begin
                        idle_cnt <= '0;
                    end else if (idle_hit) begin
                        state    <= S_IDLE;
                        outs     <= out_of(S_IDLE);
                        idle_cnt <= '0;
                    end else if (idle_cnt != IDLE_SAT) begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end
                S_IDLE: begin
                    if (!req_on) begin
                        state   <= S_RST_OFF;
                        outs    <= out_of(S_RST_OFF);
                        rst_cnt <= '0;
                    end else if (sel_diff) begin
                        state   <= S_SW;
                        outs    <= out_of(S_SW);
                        gap_cnt <= '0;
                    end else if (busy) begin
                        state    <= S_ON;
                        outs     <= out_of(S_ON);
                        idle_cnt <= '0;
                    end
                end
                S_SW: begin
                    if (!req_on) begin
                        state   <= S_RST_OFF;
                        outs    <= out_of(S_RST_OFF);
                        rst_cnt <= '0;
                    end else begin
                        // Select is applied once, after a full gated cycle; later changes wait for ON.
                        if (gap_cnt == '0)
                            clk_sel <= sel_req;
                        if (gap_cnt == GAP_LAST) begin
                            state    <= S_ON;
                            outs     <= out_of(S_ON);
                            gap_cnt  <= '0;
                            idle_cnt <= '0;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                end
                S_RST_OFF: begin
                    if (rst_cnt == RST_LAST) begin
                        state   <= S_OFF;
                        outs    <= out_of(S_OFF);
                        rst_cnt <= '0;
                    end else begin
                        rst_cnt <= rst_cnt + RST_W'(1);
                    end
                end
                default: begin
                    state <= S_OFF;
                    outs  <= out_of(S_OFF);
                end
            endcase
        end
    end

    // The select may only move on an edge where the clock was gated beforehand.
    a_sel_gated: assert property (@(posedge clk) disable iff (rst)
        !$stable(clk_sel) |-> !$past(clk_en));

endmodule

module multi_ch_crg_ctrl #(
    parameter int NUM_CH      = 2,
    parameter int SEL_W       = 1,
    parameter int RST_CYCLES  = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int SW_GAP      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ch_req_on,
    input  logic [NUM_CH-1:0]       ch_busy,
    input  logic [NUM_CH*SEL_W-1:0] ch_sel_req,
    output logic [NUM_CH-1:0]       ch_clk_en,
    output logic [NUM_CH*SEL_W-1:0] ch_clk_sel,
    output logic [NUM_CH-1:0]       ch_rst,
    output logic [NUM_CH-1:0]       ch_ready,
    output logic [NUM_CH*3-1:0]     ch_state
);
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        multi_ch_crg_lane #(
            .SEL_W       (SEL_W),
            .RST_CYCLES  (RST_CYCLES),
            .IDLE_CYCLES (IDLE_CYCLES),
            .SW_GAP      (SW_GAP)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .req_on     (ch_req_on[i]),
            .busy       (ch_busy[i]),
            .sel_req    (ch_sel_req[i*SEL_W +: SEL_W]),
            .clk_en     (ch_clk_en[i]),
            .clk_sel    (ch_clk_sel[i*SEL_W +: SEL_W]),
            .ch_rst     (ch_rst[i]),
            .ready      (ch_ready[i]),
            .state_code (ch_state[i*3 +: 3])
        );
    end

endmodule

// File: tb/tb_multi_ch_crg_ctrl.sv
// Directed bench for multi_ch_crg_ctrl: default build plus an auto-gating-disabled build.
module tb_multi_ch_crg_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_on = '0, busy = '0, sel_req = '0;
    logic [1:0] en, crst, rdy, sel;
    logic [5:0] st;
    logic [1:0] req_on_z = '0, busy_z = '0, sel_req_z = '0;
    logic [1:0] en_z, crst_z, rdy_z, sel_z;
    logic [5:0] st_z;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_ch_crg_ctrl #(.NUM_CH(2), .SEL_W(1), .RST_CYCLES(4), .IDLE_CYCLES(16), .SW_GAP(2)) dut (
        .clk(clk), .rst(rst), .ch_req_on(req_on), .ch_busy(busy), .ch_sel_req(sel_req),
        .ch_clk_en(en), .ch_clk_sel(sel), .ch_rst(crst), .ch_ready(rdy), .ch_state(st));

    multi_ch_crg_ctrl #(.NUM_CH(2), .SEL_W(1), .RST_CYCLES(4), .IDLE_CYCLES(0), .SW_GAP(2)) dut_z (
        .clk(clk), .rst(rst), .ch_req_on(req_on_z), .ch_busy(busy_z), .ch_sel_req(sel_req_z),
        .ch_clk_en(en_z), .ch_clk_sel(sel_z), .ch_rst(crst_z), .ch_ready(rdy_z), .ch_state(st_z));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Select must only move on an edge preceded by a gated cycle.
    logic [1:0] en_q = '0, sel_q = '0;
    logic       rst_q = 1'b1;
    always @(negedge clk) begin
        if (!rst && !rst_q)
            for (int i = 0; i < 2; i++)
                if (sel[i] !== sel_q[i])
                    chk($sformatf("sel_move_en_ch%0d", i), {31'd0, en_q[i]}, 32'd0);
        en_q  <= en;
        sel_q <= sel;
        rst_q <= rst;
    end

    initial begin
        step(2);
        chk("rst_en",    en,   2'b00);
        chk("rst_crst",  crst, 2'b11);
        chk("rst_sel",   sel,  2'b00);
        chk("rst_rdy",   rdy,  2'b00);
        chk("rst_state", st,   6'd0);

        // power-up of ch0; cycle 0
        rst = 1'b0; req_on = 2'b01; busy = 2'b11; req_on_z = 2'b01;
        step();
        chk("t1_en_c1",    en,   2'b01);
        chk("t1_crst_c1",  crst, 2'b11);
        chk("t1_state_c1", st,   {3'd0, 3'd1});
        step(3);
        chk("t1_crst_c4",  crst, 2'b11);
        chk("t1_rdy_c4",   rdy,  2'b00);
        step();
        chk("t1_rdy_c5",   rdy,  2'b01);
        chk("t1_crst_c5",  crst, 2'b10);
        chk("t1_state_c5", st,   {3'd0, 3'd2});
        chk("t1_ch1_en",   en,   2'b01);

        // auto-gate after 16 idle cycles, then wake
        busy = 2'b10;
        step(15);
        chk("t2_en_15",    en, 2'b01);
        chk("t2_state_15", st, {3'd0, 3'd2});
        step();
        chk("t2_en_16",    en,  2'b00);
        chk("t2_state_16", st,  {3'd0, 3'd3});
        chk("t2_rdy_16",   rdy, 2'b00);
        busy = 2'b11;
        step();
        chk("t2_wake_en",  en,  2'b01);
        chk("t2_wake_rdy", rdy, 2'b01);

        // clock select switch
        sel_req = 2'b01;
        step();
        chk("t3_en_g1",    en,  2'b00);
        chk("t3_sel_g1",   sel, 2'b00);
        chk("t3_state_g1", st,  {3'd0, 3'd4});
        step();
        chk("t3_en_g2",    en,  2'b00);
        chk("t3_sel_g2",   sel, 2'b01);
        step();
        chk("t3_en_g3",    en,  2'b00);
        chk("t3_state_g3", st,  {3'd0, 3'd4});
        step();
        chk("t3_en_on",    en,  2'b01);
        chk("t3_rdy_on",   rdy, 2'b01);
        chk("t3_sel_on",   sel, 2'b01);

        // power-down with re-request during RST_OFF
        req_on = 2'b00;
        step();
        chk("t4_en_r1",    en,   2'b01);
        chk("t4_crst_r1",  crst, 2'b11);
        chk("t4_rdy_r1",   rdy,  2'b00);
        chk("t4_state_r1", st,   {3'd0, 3'd5});
        req_on = 2'b01;
        step(2);
        chk("t4_state_r3", st, {3'd0, 3'd5});
        step();
        chk("t4_state_r4", st, {3'd0, 3'd5});
        chk("t4_en_r4",    en, 2'b01);
        step();
        chk("t4_state_off", st,   {3'd0, 3'd0});
        chk("t4_en_off",    en,   2'b00);
        chk("t4_crst_off",  crst, 2'b11);
        step();
        chk("t4_state_re", st,  {3'd0, 3'd1});
        chk("t4_en_re",    en,  2'b01);
        chk("t4_sel_re",   sel, 2'b01);

        // async reset in the middle of RST_ON on both channels
        req_on = 2'b11; sel_req = 2'b11;
        step();
        chk("t5_state_pre", st,  {3'd1, 3'd1});
        chk("t5_sel_pre",   sel, 2'b11);
        rst = 1'b1;
        #1;
        chk("t5_en",    en,   2'b00);
        chk("t5_crst",  crst, 2'b11);
        chk("t5_sel",   sel,  2'b00);
        chk("t5_rdy",   rdy,  2'b00);
        chk("t5_state", st,   6'd0);
        chk("t5_z_state", st_z, 6'd0);
        step();
        rst = 1'b0; req_on = 2'b00; sel_req = 2'b00;

        // auto-gating disabled build stays ON with busy low
        step(5);
        chk("t6_z_state_on", st_z, {3'd0, 3'd2});
        step(100);
        chk("t6_z_state", st_z,  {3'd0, 3'd2});
        chk("t6_z_en",    en_z,  2'b01);
        chk("t6_z_rdy",   rdy_z, 2'b01);
        chk("t6_main_off", st,   6'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
